// File: rtl/segment_validity_tracker_pkg.sv
// Shared definitions for the segment validity tracker and its byte decoder.
// Pad byte is used only when SEG_VALIDITY_PAD_EN is defined.
package segment_validity_tracker_pkg;

  localparam int DEF_BUS_SIZE = 32;
  localparam int BYTES_PER_WORD = DEF_BUS_SIZE / 8;
  localparam logic [7:0] PAD_BYTE = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/segment_validity_tracker_byte_validity_decoder.sv
// Maps remaining segment bytes to a per-byte validity vector,
// the valid byte count of the current word and a last-word flag.
module byte_validity_decoder
  import segment_validity_tracker_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int BPW   = BYTES_PER_WORD,
  localparam int NB_W = $clog2(BPW) + 1
) (
  input  logic [LEN_W-1:0] rem,
  output logic [BPW-1:0]   validity,
  output logic [NB_W-1:0]  nbytes,
  output logic             last
);

  logic full;

  always_comb begin
    full   = rem >= LEN_W'(BPW);
    last   = rem <= LEN_W'(BPW);
    nbytes = full ? NB_W'(BPW) : NB_W'(rem);
    for (int i = 0; i < BPW; i++) begin
      validity[i] = rem > LEN_W'(i);
    end
  end

endmodule

// File: rtl/segment_validity_tracker.sv
// Tracks bytes left in a segment and registers each word with validity info.
// Define SEG_VALIDITY_PAD_EN to insert a 0x01 pad byte and add dout_pad.
module segment_validity_tracker
  import segment_validity_tracker_pkg::*;
#(
  parameter int BUS_SIZE = DEF_BUS_SIZE,
  parameter int LEN_W    = 16,
  localparam int BPW     = BUS_SIZE / 8,
  localparam int NB_W    = $clog2(BPW) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LEN_W-1:0]    seg_len,
  input  logic                seg_start,
  output logic                seg_ready,
  input  logic [BUS_SIZE-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [BUS_SIZE-1:0] dout,
  output logic [BPW-1:0]      dout_validity,
  output logic                dout_last,
  output logic [NB_W-1:0]     dout_nbytes,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                seg_done
`ifdef SEG_VALIDITY_PAD_EN
  ,
  output logic                dout_pad
`endif
);

  state_e state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [BUS_SIZE-1:0] dout_q, dout_d;
  logic [BPW-1:0] val_q, val_d;
  logic [NB_W-1:0] nb_q, nb_d;
  logic last_q, last_d;
  logic dv_q, dv_d;
  logic done_q, done_d;
  logic pad_q, pad_d;

  logic [BPW-1:0] dec_val;
  logic [NB_W-1:0] dec_nb;
  logic dec_last;
  logic [BUS_SIZE-1:0] data_w;
  logic in_hs, out_hs;
  logic pad_w;

  byte_validity_decoder #(
    .LEN_W(LEN_W),
    .BPW  (BPW)
  ) u_dec (
    .rem     (rem_q),
    .validity(dec_val),
    .nbytes  (dec_nb),
    .last    (dec_last)
  );

  assign seg_ready = state_q == S_IDLE;
  assign din_ready = (state_q == S_ACTIVE) && (!dv_q || dout_ready);
  assign in_hs     = din_valid && din_ready;
  assign out_hs    = dv_q && dout_ready;

  always_comb begin
    data_w = din;
    pad_w  = 1'b0;
`ifdef SEG_VALIDITY_PAD_EN
    pad_w = dec_last && (dec_nb != NB_W'(BPW));
    for (int i = 0; i < BPW; i++) begin
      if (pad_w && (dec_nb == NB_W'(i))) begin
        data_w[8*i +: 8] = PAD_BYTE;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    val_d   = val_q;
    nb_d    = nb_q;
    last_d  = last_q;
    dv_d    = dv_q;
    pad_d   = pad_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (seg_start) begin
          if (seg_len != '0) begin
            rem_d   = seg_len;
            state_d = S_ACTIVE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (in_hs) begin
          rem_d = rem_q - LEN_W'(dec_nb);
          if (dec_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_hs) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new word replaces the register even while the old one leaves.
    if (in_hs) begin
      dout_d = data_w;
      val_d  = dec_val;
      nb_d   = dec_nb;
      last_d = dec_last;
      pad_d  = pad_w;
      dv_d   = 1'b1;
    end else if (out_hs) begin
      dv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dout_q  <= '0;
      val_q   <= '0;
      nb_q    <= '0;
      last_q  <= 1'b0;
      dv_q    <= 1'b0;
      pad_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      val_q   <= val_d;
      nb_q    <= nb_d;
      last_q  <= last_d;
      dv_q    <= dv_d;
      pad_q   <= pad_d;
      done_q  <= done_d;
    end
  end

  assign dout          = dout_q;
  assign dout_validity = val_q;
  assign dout_nbytes   = nb_q;
  assign dout_last     = last_q;
  assign dout_valid    = dv_q;
  assign seg_done      = done_q;
`ifdef SEG_VALIDITY_PAD_EN
  assign dout_pad      = pad_q;
`endif

endmodule

// File: tb/tb_segment_validity_tracker.sv
// Self-checking bench: vector table, corner sequences, random segments.
// Works with and without SEG_VALIDITY_PAD_EN.
module tb_segment_validity_tracker;

  localparam int BPW = 4;
`ifdef SEG_VALIDITY_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] seg_len;
  logic        seg_start;
  logic        seg_ready;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic [3:0]  dout_validity;
  logic        dout_last;
  logic [2:0]  dout_nbytes;
  logic        dout_valid;
  logic        dout_ready;
  logic        seg_done;
  logic        pad_obs;

  always #5 clk = ~clk;

  segment_validity_tracker #(.BUS_SIZE(32), .LEN_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_len      (seg_len),
    .seg_start    (seg_start),
    .seg_ready    (seg_ready),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .dout         (dout),
    .dout_validity(dout_validity),
    .dout_last    (dout_last),
    .dout_nbytes  (dout_nbytes),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .seg_done     (seg_done)
`ifdef SEG_VALIDITY_PAD_EN
    ,
    .dout_pad     (pad_obs)
`endif
  );

`ifndef SEG_VALIDITY_PAD_EN
  assign pad_obs = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  v;
    logic [2:0]  nb;
    logic        last;
    logic        pad;
  } exp_t;

  exp_t sbq[$];

  // Word k of a len-byte segment, derived from byte arithmetic alone.
  function automatic exp_t model_word(int len, int k, logic [31:0] d);
    exp_t e;
    int remain;
    int nb;
    remain = len - BPW * k;
    nb     = (remain >= BPW) ? BPW : remain;
    e.d    = d;
    e.nb   = 3'(nb);
    e.v    = 4'((1 << nb) - 1);
    e.last = remain <= BPW;
    e.pad  = 1'b0;
    if (PAD_ON && e.last && nb < BPW) begin
      e.d[8*nb +: 8] = 8'h01;
      e.pad = 1'b1;
    end
    return e;
  endfunction

  task automatic run_seg(input int len, input int vld_pct, input int rdy_pct,
                         input bit poke, output int words,
                         output logic [3:0] lv, output logic [2:0] lnb,
                         output logic lpad, output int lat);
    int nw;
    int k;
    int cyc;
    int last_out;
    bit done;
    exp_t e;
    nw = (len + BPW - 1) / BPW;
    k = 0;
    cyc = 0;
    last_out = -100;
    done = 1'b0;
    words = 0;
    lv = '0;
    lnb = '0;
    lpad = 1'b0;
    lat = -1;
    sbq.delete();
    seg_len = 16'(len);
    seg_start = 1'b1;
    din_valid = 1'b0;
    #1 chk("seg_ready_at_start", seg_ready, 1);
    @(negedge clk);
    seg_start = 1'b0;
    while (!done && cyc < 3000) begin
      din_valid  = $urandom_range(99) < vld_pct;
      din        = $urandom;
      dout_ready = $urandom_range(99) < rdy_pct;
      if (poke && cyc == 2) begin
        seg_start = 1'b1;
        seg_len   = 16'd100;
      end else begin
        seg_start = 1'b0;
      end
      #1;
      if (seg_done) begin
        done = 1'b1;
        lat  = cyc - last_out;
      end
      if (dout_valid && dout_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("word", {dout, dout_validity, dout_nbytes, dout_last},
              {e.d, e.v, e.nb, e.last});
          chk("word_pad", pad_obs, e.pad);
          words++;
          last_out = cyc;
          if (dout_last) begin
            lv   = dout_validity;
            lnb  = dout_nbytes;
            lpad = pad_obs;
          end
        end
      end
      if (din_valid && din_ready) begin
        if (k < nw) begin
          sbq.push_back(model_word(len, k, din));
          k++;
        end else begin
          chk("extra_word_accepted", 1, 0);
        end
      end
      cyc++;
      @(negedge clk);
    end
    seg_start  = 1'b0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    if (!done) chk("seg_done_timeout", 0, 1);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("words_in", k, nw);
  endtask

  typedef struct {
    int         len;
    int         words;
    logic [3:0] lv;
    logic [2:0] lnb;
    logic       lpad;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int w;
    int lat;
    logic [3:0] lv;
    logic [2:0] lnb;
    logic lpad;
    int len;

    tbl[0] = '{8,  2, 4'hF, 3'd4, 1'b0};
    tbl[1] = '{6,  2, 4'h3, 3'd2, PAD_ON};
    tbl[2] = '{1,  1, 4'h1, 3'd1, PAD_ON};
    tbl[3] = '{4,  1, 4'hF, 3'd4, 1'b0};
    tbl[4] = '{13, 4, 4'h1, 3'd1, PAD_ON};
    tbl[5] = '{3,  1, 4'h7, 3'd3, PAD_ON};
    tbl[6] = '{16, 4, 4'hF, 3'd4, 1'b0};

    rst_n = 1'b0;
    seg_len = '0;
    seg_start = 1'b0;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    #1;
    chk("rst_outputs", {dout, dout_validity, dout_nbytes, dout_last,
        dout_valid, seg_done, pad_obs}, 0);
    chk("rst_ready", {seg_ready, din_ready}, 2'b10);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_seg(tbl[i].len, 100, 100, 1'b0, w, lv, lnb, lpad, lat);
      chk($sformatf("tbl%0d_words", i), w, tbl[i].words);
      chk($sformatf("tbl%0d_last_val", i), lv, tbl[i].lv);
      chk($sformatf("tbl%0d_last_nb", i), lnb, tbl[i].lnb);
      chk($sformatf("tbl%0d_last_pad", i), lpad, tbl[i].lpad);
      chk($sformatf("tbl%0d_done_lat", i), lat, 1);
    end

    // zero-length segment
    seg_len = 16'd0;
    seg_start = 1'b1;
    @(negedge clk);
    seg_start = 1'b0;
    #1;
    chk("zero_done", seg_done, 1);
    chk("zero_no_word", dout_valid, 0);
    chk("zero_seg_ready", seg_ready, 1);
    @(negedge clk);
    #1 chk("zero_done_pulse", seg_done, 0);
    @(negedge clk);

    // output stall with a 12-byte segment
    seg_len = 16'd12;
    seg_start = 1'b1;
    @(negedge clk);
    seg_start = 1'b0;
    din_valid = 1'b1;
    din = 32'hAAAA_0001;
    dout_ready = 1'b0;
    #1 chk("stall_first_ready", din_ready, 1);
    @(negedge clk);
    din = 32'hBBBB_0002;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("stall_dout", {dout_valid, dout}, {1'b1, 32'hAAAA_0001});
      chk("stall_din_ready", din_ready, 0);
      @(negedge clk);
    end
    dout_ready = 1'b1;
    #1 chk("release_a", {dout_valid, dout}, {1'b1, 32'hAAAA_0001});
    @(negedge clk);
    din = 32'hCCCC_0003;
    #1 chk("release_b", {dout_valid, dout, dout_last},
           {1'b1, 32'hBBBB_0002, 1'b0});
    @(negedge clk);
    din_valid = 1'b0;
    #1 chk("release_c", {dout_valid, dout, dout_validity, dout_last},
           {1'b1, 32'hCCCC_0003, 4'hF, 1'b1});
    @(negedge clk);
    #1 chk("release_done", {seg_done, dout_valid}, 2'b10);
    dout_ready = 1'b0;
    @(negedge clk);

    // reset in the middle of a segment
    seg_len = 16'd12;
    seg_start = 1'b1;
    @(negedge clk);
    seg_start = 1'b0;
    din_valid = 1'b1;
    din = 32'h1234_5678;
    @(negedge clk);
    din_valid = 1'b0;
    #1 chk("midrst_word_held", dout_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {dout, dout_validity, dout_nbytes, dout_last,
        dout_valid, seg_done}, 0);
    chk("midrst_ready", {seg_ready, din_ready}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_seg(4, 100, 100, 1'b0, w, lv, lnb, lpad, lat);
    chk("postrst_words", w, 1);
    chk("postrst_val", lv, 4'hF);

    // seg_start while busy must be ignored
    run_seg(12, 100, 100, 1'b1, w, lv, lnb, lpad, lat);
    chk("poke_words", w, 3);
    chk("poke_idle", seg_ready, 1);

    // random segments with random backpressure
    for (int r = 0; r < 30; r++) begin
      len = $urandom_range(40, 1);
      run_seg(len, $urandom_range(100, 30), $urandom_range(100, 30),
              (len >= 9) && $urandom_range(1), w, lv, lnb, lpad, lat);
      chk("rand_words", w, (len + BPW - 1) / BPW);
      chk("rand_done_lat", lat, 1);
      chk("rand_seg_ready", seg_ready, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/segment_validity_tracker.md
Name: segment_validity_tracker

Overview:
- Upstream neighbour of the per-byte validity masking stage in the mode datapath.
- Receives a segment byte length (AD, message or tag) plus a stream of BUS_SIZE-bit words, and counts the bytes remaining.
- Emits each word registered, with a per-byte validity vector, a last-word flag and the number of valid bytes in that word.
- Its output feeds the masking stage directly, so bytes beyond the segment end are zeroed before absorption.

Parameters:
- BUS_SIZE, 32, data bus width in bits; must be a multiple of 8.
- LEN_W, 16, width of the segment byte-length field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_len  input  LEN_W  segment length in bytes.
- seg_start  input  1  load seg_len; accepted when seg_ready=1.
- seg_ready  output  1  high in IDLE.
- din  input  BUS_SIZE  data word.
- din_valid  input  1  din valid.
- din_ready  output  1  din accepted when din_valid & din_ready.
- dout  output  BUS_SIZE  registered data word.
- dout_validity  output  BUS_SIZE/8  per-byte validity; bit i covers byte i (LSB byte first).
- dout_last  output  1  final word of the segment.
- dout_nbytes  output  clog2(BUS_SIZE/8)+1  count of valid bytes in dout.
- dout_valid  input/output: output  1  dout fields valid.
- dout_ready  input  1  downstream accepts when dout_valid & dout_ready.
- seg_done  output  1  one-cycle pulse when the segment completes.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, rem=0.
  - dout, dout_validity, dout_nbytes, dout_last, dout_valid = 0.
  - seg_done = 0.
  - Reset mid-segment discards all state; no partial word is emitted.
- FSM:
  - IDLE: seg_ready=1, din_ready=0.
  - seg_start with seg_len>0: rem<=seg_len, go to ACTIVE.
  - seg_start with seg_len=0: stay in IDLE, pulse seg_done the next cycle; no word is emitted.
  - ACTIVE: seg_ready=0; seg_start is ignored.
  - din_ready = !dout_valid | dout_ready. This gives a single output register with full throughput: one word per cycle under continuous ready.
  - On din handshake:
    - dout<=din; dout_valid<=1.
    - If rem>=BUS_SIZE/8: dout_validity<=all ones, dout_nbytes<=BUS_SIZE/8.
    - Otherwise: dout_validity bit i<=(i<rem), dout_nbytes<=rem.
    - dout_last<=(rem<=BUS_SIZE/8).
    - rem<=rem-min(rem,BUS_SIZE/8), saturating at 0 with no wrap.
    - If that word is last, go to DRAIN.
  - DRAIN: din_ready=0. When the last word handshakes downstream: dout_valid<=0, seg_done pulses for 1 cycle, return to IDLE.
  - A new seg_start is accepted only after IDLE is reached, i.e. the cycle after seg_done asserts, or later.
- Output-register handshake, applies in every state:
  - dout_valid clears on a downstream handshake with no simultaneous din handshake.
  - dout_* fields hold stable while dout_valid & !dout_ready.
- Latency: din handshake to dout_valid is 1 cycle.
- Simultaneous input and output handshake in the same cycle: the output register is replaced, with no bubble.
- Arithmetic: rem is LEN_W bits and the compare is against the constant BUS_SIZE/8. Maximum segment length is 2^LEN_W-1 bytes.

Optional Feature:
- Macro: SEG_VALIDITY_PAD_EN.
- Defined:
  - On a last word with dout_nbytes<BUS_SIZE/8, byte lane dout_nbytes of dout is forced to 8'h01 (domain-separation pad); higher invalid lanes pass through unchanged.
  - A new output, dout_pad (1 bit), is high when a pad byte was inserted.
  - On a full-length last word no pad is inserted and dout_pad=0.
- Undefined: dout is an exact copy of din, and the dout_pad port is absent.

Decomposition:
- Shared mode package holds:
  - FSM state encoding (IDLE, ACTIVE, DRAIN).
  - BYTES_PER_WORD = BUS_SIZE/8.
  - Pad constant PAD_BYTE = 8'h01.
- One natural sub-module: byte_validity_decoder. Combinational; maps rem to the validity vector, nbytes and last. It is reused by the tag-compare path.

Test Plan:
- seg_len=8, BUS_SIZE=32, two words, dout_ready=1 → validity 4'hF, then 4'hF with last=1; nbytes 4, 4; seg_done one cycle after the second handshake.
- seg_len=6 → word 1: validity 4'hF, nbytes=4. Word 2: validity 4'h3, nbytes=2, last=1. With SEG_VALIDITY_PAD_EN: byte 2 of word 2 = 8'h01, dout_pad=1.
- seg_len=0 → no dout_valid; seg_done pulses; seg_ready stays 1.
- seg_len=12 with dout_ready held low for 3 cycles after the first word → dout stable and din_ready=0 throughout; releasing ready gives back-to-back words with no loss.
- Assert rst_n=0 after 1 of 3 words → all outputs 0 immediately; after release seg_ready=1 and a new seg_len=4 yields one word with validity 4'hF, last=1.
- seg_start pulsed while ACTIVE with seg_len=100 → ignored; the current segment's rem is unaffected.
